simon_input_checker: RTL and testbench

Player-side counterpart of the Simon Says color playback sequencer. After the sequencer has shown the first `round_len` colors of the packed `colors` word, this block takes the player's debounced button presses. It checks each press in order against the same sequence and reports a round pass or fail to the game controller. It also enforces a per-press timeout and requires each button to be released before the next press counts.

---
 rtl/simon_pkg.sv | 25 ++
 rtl/btn_onehot_decode.sv | 23 ++
 rtl/simon_input_checker.sv | 132 +++++++++++++
 tb/tb_simon_input_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says playback sequencer and input checker.
package simon_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] BLUE   = 2'd2;
  localparam logic [1:0] YELLOW = 2'd3;

  localparam int MAX_LEN = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_PRESS,
    WAIT_RELEASE,
    PASS,
    FAIL
  } chk_state_t;

  // Color i of a packed sequence lives in bits [2i+1:2i].
  function automatic logic [1:0] color_at(input logic [31:0] seq, input logic [3:0] i);
    return seq[{i, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/btn_onehot_decode.sv
// Encodes a one-hot button vector into a 2-bit color; onehot flags a clean single press.
module btn_onehot_decode
  import simon_pkg::*;
(
  input  logic [3:0] btn,
  output logic [1:0] color,
  output logic       onehot
);

  // Exactly one button high maps to its color; anything else is not one-hot.
  always_comb begin
    color  = RED;
    onehot = 1'b1;
    case (btn)
      4'b0001: color = RED;
      4'b0010: color = GREEN;
      4'b0100: color = BLUE;
      4'b1000: color = YELLOW;
      default: onehot = 1'b0;
    endcase
  end

endmodule

// File: rtl/simon_input_checker.sv
// Checks the player's button presses against the sequence just played back.
//
// state        | meaning
// IDLE         | waiting for start
// ARM          | round accepted, waiting for all buttons released
// WAIT_PRESS   | waiting for the next press, timeout running
// WAIT_RELEASE | correct press seen, waiting for release
// PASS         | round_pass pulse cycle
// FAIL         | round_fail pulse cycle
module simon_input_checker
  import simon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int MAX_LEN        = simon_pkg::MAX_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] colors,
  input  logic [4:0]  round_len,
  input  logic [3:0]  btn,
  output logic        busy,
  output logic        press_valid,
  output logic [1:0]  pressed_color,
  output logic [3:0]  expected_idx,
  output logic        round_pass,
  output logic        round_fail
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

  chk_state_t    state;
  logic [31:0]   colors_q;
  logic [4:0]    len_q;
  logic [CW-1:0] cnt;
  logic [4:0]    len_clamped;
  logic [1:0]    btn_color;
  logic          btn_onehot;

  btn_onehot_decode u_decode (
    .btn    (btn),
    .color  (btn_color),
    .onehot (btn_onehot)
  );

  // Over-long rounds are played as the full sequence.
  always_comb begin
    len_clamped = (round_len > LEN_MAX) ? LEN_MAX : round_len;
  end

  // Round FSM; all outputs registered, pulses default low each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      colors_q      <= '0;
      len_q         <= '0;
      cnt           <= '0;
      expected_idx  <= '0;
      busy          <= 1'b0;
      press_valid   <= 1'b0;
      pressed_color <= '0;
      round_pass    <= 1'b0;
      round_fail    <= 1'b0;
    end else begin
      press_valid <= 1'b0;
      round_pass  <= 1'b0;
      round_fail  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            colors_q     <= colors;
            len_q        <= len_clamped;
            expected_idx <= '0;
            cnt          <= '0;
            if (len_clamped == 5'd0) begin
              state      <= PASS;
              round_pass <= 1'b1;
            end else begin
              state <= ARM;
              busy  <= 1'b1;
            end
          end
        end
        ARM: begin
          if (btn == 4'b0000) begin
            cnt   <= '0;
            state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          // A press seen on the final counter value still wins over the timeout.
          if (btn != 4'b0000) begin
            if (!btn_onehot || (btn_color != color_at(colors_q, expected_idx))) begin
              state      <= FAIL;
              round_fail <= 1'b1;
              busy       <= 1'b0;
            end else begin
              press_valid   <= 1'b1;
              pressed_color <= btn_color;
              cnt           <= '0;
              state         <= WAIT_RELEASE;
            end
          end else if (cnt == CNT_LAST) begin
            state      <= FAIL;
            round_fail <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_RELEASE: begin
          if (btn == 4'b0000) begin
            if ({1'b0, expected_idx} == (len_q - 5'd1)) begin
              state      <= PASS;
              round_pass <= 1'b1;
              busy       <= 1'b0;
            end else begin
              expected_idx <= expected_idx + 4'd1;
              cnt          <= '0;
              state        <= WAIT_PRESS;
            end
          end
        end
        PASS, FAIL: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_input_checker.sv
// Scoreboard bench for simon_input_checker: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_simon_input_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] colors = '0;
  logic [4:0]  round_len = '0;
  logic [3:0]  btn = '0;
  logic        busy;
  logic        press_valid;
  logic [1:0]  pressed_color;
  logic [3:0]  expected_idx;
  logic        round_pass;
  logic        round_fail;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // kind: 0 = correct press, 1 = round pass, 2 = round fail
  typedef struct {
    int         kind;
    logic [1:0] color;
    logic [3:0] idx;
    int         stamp;
  } exp_t;

  exp_t sbq[$];

  simon_input_checker #(.TIMEOUT_CYCLES(20), .MAX_LEN(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .colors        (colors),
    .round_len     (round_len),
    .btn           (btn),
    .busy          (busy),
    .press_valid   (press_valid),
    .pressed_color (pressed_color),
    .expected_idx  (expected_idx),
    .round_pass    (round_pass),
    .round_fail    (round_fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [1:0] col, input logic [3:0] idx, input int stamp);
    exp_t e;
    e.kind  = kind;
    e.color = col;
    e.idx   = idx;
    e.stamp = stamp;
    sbq.push_back(e);
  endtask

  // Monitor: every DUT pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (round_pass && round_fail)
        check("pass_and_fail_together", 32'(1), 32'(0));
      if (press_valid || round_pass || round_fail) begin
        int   kind;
        exp_t e;
        kind = press_valid ? 0 : (round_pass ? 1 : 2);
        if (sbq.size() == 0) begin
          check("unexpected_event_kind", 32'(kind), 32'(99));
        end else begin
          e = sbq.pop_front();
          check("event_kind", 32'(kind), 32'(e.kind));
          check("event_cycle", 32'(cyc), 32'(e.stamp));
          check("event_idx", 32'(expected_idx), 32'(e.idx));
          if (kind == 0)
            check("pressed_color", 32'(pressed_color), 32'(e.color));
          else
            check("busy_at_result", 32'(busy), 32'(0));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_press_valid"}, 32'(press_valid), 32'(0));
    check({tag, "_pressed_color"}, 32'(pressed_color), 32'(0));
    check({tag, "_expected_idx"}, 32'(expected_idx), 32'(0));
    check({tag, "_round_pass"}, 32'(round_pass), 32'(0));
    check({tag, "_round_fail"}, 32'(round_fail), 32'(0));
  endtask

  // Drives a one-cycle start; returns the cycle count at which it was driven.
  task automatic do_start(input logic [31:0] c, input logic [4:0] len, output int t0);
    @(negedge clk);
    start     = 1'b1;
    colors    = c;
    round_len = len;
    t0        = cyc;
    if (len == 5'd0) push(1, 2'd0, 4'd0, t0 + 1);
    @(negedge clk);
    start = 1'b0;
    if (len != 5'd0) check("busy_after_start", 32'(busy), 32'(1));
  endtask

  // Press, hold, release. kind 0 expects a correct press, 2 a fail.
  task automatic press(input logic [3:0] b, input int kind, input logic [1:0] col,
                       input logic [3:0] idx, input bit last);
    btn = b;
    push(kind, col, idx, cyc + 1);
    idle(2);
    btn = 4'b0000;
    if (kind == 0 && last) push(1, 2'd0, idx, cyc + 1);
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t0;

    idle(3);
    check_quiet("reset");
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    check_quiet("post_reset");

    // Correct round 0,1,2,3
    do_start(32'h0000_00E4, 5'd4, t0);
    idle(2);
    press(4'b0001, 0, 2'd0, 4'd0, 1'b0);
    press(4'b0010, 0, 2'd1, 4'd1, 1'b0);
    press(4'b0100, 0, 2'd2, 4'd2, 1'b0);
    press(4'b1000, 0, 2'd3, 4'd3, 1'b1);
    idle(2);

    // Wrong color on the second press
    do_start(32'h0000_00E4, 5'd4, t0);
    idle(2);
    press(4'b0001, 0, 2'd0, 4'd0, 1'b0);
    press(4'b1000, 2, 2'd0, 4'd1, 1'b0);
    idle(2);

    // Two buttons at once on the first press
    do_start(32'h0000_00E4, 5'd4, t0);
    idle(2);
    press(4'b0011, 2, 2'd0, 4'd0, 1'b0);
    idle(2);

    // Timeout: WAIT_PRESS entered at t0+2, fail 20 cycles later
    do_start(32'h0000_00E4, 5'd1, t0);
    push(2, 2'd0, 4'd0, t0 + 22);
    idle(28);

    // Press sampled on the last counter value is accepted
    do_start(32'h0000_00E4, 5'd1, t0);
    while (cyc < t0 + 21) @(negedge clk);
    press(4'b0001, 0, 2'd0, 4'd0, 1'b1);
    idle(2);

    // Button held across start does not count
    btn = 4'b0001;
    do_start(32'h0000_00E4, 5'd1, t0);
    idle(5);
    btn = 4'b0000;
    idle(3);
    press(4'b0001, 0, 2'd0, 4'd0, 1'b1);
    idle(2);

    // Zero-length round passes immediately
    do_start(32'h0000_00E4, 5'd0, t0);
    idle(3);

    // Length 20 clamps to 16 presses
    do_start(32'hE4E4_E4E4, 5'd20, t0);
    idle(2);
    for (int i = 0; i < 16; i++) begin
      press(4'b0001 << (i % 4), 0, 2'(i % 4), 4'(i), i == 15);
    end
    idle(2);

    // Reset while a button is held
    do_start(32'h0000_00E4, 5'd4, t0);
    idle(2);
    btn = 4'b0001;
    push(0, 2'd0, 4'd0, cyc + 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_quiet("mid_round_reset");
    idle(2);
    btn   = 4'b0000;
    reset = 1'b0;
    idle(2);
    check_quiet("after_mid_reset");

    // Normal round after reset
    do_start(32'h0000_00E4, 5'd2, t0);
    idle(2);
    press(4'b0001, 0, 2'd0, 4'd0, 1'b0);
    press(4'b0010, 0, 2'd1, 4'd1, 1'b1);
    idle(4);

    check("scoreboard_drain", 32'(sbq.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
